// File: rtl/pong_pkg.sv
// Shared Pong definitions: serve FSM states, screen geometry and ball centre position.
`timescale 1ns/1ps
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        LAUNCH = 2'd2,
        LIVE   = 2'd3
    } serve_state_t;

    localparam int H_RES     = 640;
    localparam int V_RES     = 480;
    localparam int BALL_SIZE = 8;

    localparam int MAX_X    = H_RES - BALL_SIZE;
    localparam int MAX_Y    = V_RES - BALL_SIZE;
    localparam int CENTRE_X = (H_RES - BALL_SIZE) / 2;
    localparam int CENTRE_Y = (V_RES - BALL_SIZE) / 2;

    // The generator nominally yields 1..3; a zero would freeze the vertical axis.
    function automatic logic [1:0] map_speed(input logic [1:0] r);
        return (r == 2'd0) ? 2'd1 : r;
    endfunction

endpackage

// File: rtl/ball_axis_step.sv
// One-axis position step: move pos by speed in direction dir, clamp to [0, MAX_POS],
// and reverse direction at the limit only when BOUNCE is set.
`timescale 1ns/1ps
module ball_axis_step #(
    parameter int MAX_POS = 632,
    parameter bit BOUNCE  = 1'b1
) (
    input  logic [11:0] pos,
    input  logic        dir,
    input  logic [3:0]  speed,
    output logic [11:0] next_pos,
    output logic        next_dir
);

    logic [12:0] sum;

    // One extra bit so an overshoot past MAX_POS is seen before any wrap.
    assign sum = {1'b0, pos} + {9'd0, speed};

    always_comb begin
        next_pos = pos;
        next_dir = dir;
        if (dir) begin
            if (sum > 13'(MAX_POS)) begin
                next_pos = 12'(MAX_POS);
                next_dir = BOUNCE ? 1'b0 : dir;
            end else begin
                next_pos = sum[11:0];
            end
        end else begin
            if (pos < {8'd0, speed}) begin
                next_pos = '0;
                next_dir = BOUNCE ? 1'b1 : dir;
            end else begin
                next_pos = pos - {8'd0, speed};
            end
        end
    end

endmodule

// File: rtl/ball_serve_ctrl.sv
// Serve/flight controller: holds the ball at centre for SERVE_DELAY frames after a score,
// launches with a random vertical speed, then steps once per frame. Optional speed-up: BALL_SPEEDUP_EN.
`timescale 1ns/1ps
module ball_serve_ctrl
    import pong_pkg::*;
#(
    parameter int SERVE_DELAY = 60,
    parameter int X_SPEED     = 2
`ifdef BALL_SPEEDUP_EN
    ,
    parameter int X_SPEED_MAX = 6
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        game_en,
    input  logic        p1_score,
    input  logic        p2_score,
    input  logic        paddle_hit,
    input  logic [1:0]  rand_in,
    output logic        rand_adv,
    output logic [11:0] ball_x,
    output logic [11:0] ball_y,
    output logic        dir_x,
    output logic        dir_y,
    output logic [1:0]  speed_y,
    output logic        ball_live,
    output logic [1:0]  state_o
);

    localparam int                CNT_W    = $clog2(SERVE_DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);

    serve_state_t     state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [11:0]      ball_x_d, ball_y_d, x_step_pos, y_step_pos;
    logic             dir_x_d, dir_y_d, x_step_dir, y_step_dir, dir_x_eff, score;
    logic [1:0]       speed_y_d;
    logic [3:0]       x_speed;

`ifdef BALL_SPEEDUP_EN
    logic [3:0] x_speed_q, x_speed_d;
    logic [1:0] hit_cnt, hit_cnt_d;
    assign x_speed = x_speed_q;
`else
    assign x_speed = 4'(X_SPEED);
`endif

    assign score     = p1_score | p2_score;
    // A paddle hit coincident with frame_tick reverses before the move.
    assign dir_x_eff = dir_x ^ paddle_hit;

    ball_axis_step #(.MAX_POS(MAX_X), .BOUNCE(1'b0)) u_x_step (
        .pos(ball_x), .dir(dir_x_eff), .speed(x_speed),
        .next_pos(x_step_pos), .next_dir(x_step_dir)
    );

    ball_axis_step #(.MAX_POS(MAX_Y), .BOUNCE(1'b1)) u_y_step (
        .pos(ball_y), .dir(dir_y), .speed({2'd0, speed_y}),
        .next_pos(y_step_pos), .next_dir(y_step_dir)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        // NOTE: every target gets a hold-value default first, so no path can infer a latch.
        state_d   = state;
        cnt_d     = cnt;
        ball_x_d  = ball_x;
        ball_y_d  = ball_y;
        dir_x_d   = dir_x;
        dir_y_d   = dir_y;
        speed_y_d = speed_y;
`ifdef BALL_SPEEDUP_EN
        x_speed_d = x_speed_q;
        hit_cnt_d = hit_cnt;
`endif
        if (!game_en) begin
            state_d  = IDLE;
            ball_x_d = 12'(CENTRE_X);
            ball_y_d = 12'(CENTRE_Y);
        end else begin
            case (state)
                IDLE: begin
                    state_d  = HOLD;
                    cnt_d    = '0;
                    ball_x_d = 12'(CENTRE_X);
                    ball_y_d = 12'(CENTRE_Y);
`ifdef BALL_SPEEDUP_EN
                    x_speed_d = 4'(X_SPEED);
                    hit_cnt_d = '0;
`endif
                end
                HOLD: begin
                    ball_x_d = 12'(CENTRE_X);
                    ball_y_d = 12'(CENTRE_Y);
                    if (score) begin
                        cnt_d   = '0;
                        dir_x_d = ~p1_score;
                    end else if (frame_tick) begin
                        if (cnt == CNT_LAST) state_d = LAUNCH;
                        else                 cnt_d   = cnt + 1'b1;
                    end
                end
                LAUNCH: begin
                    speed_y_d = map_speed(rand_in);
                    dir_y_d   = rand_in[0];
                    state_d   = LIVE;
                end
                LIVE: begin
                    if (score) begin
                        state_d  = HOLD;
                        cnt_d    = '0;
                        ball_x_d = 12'(CENTRE_X);
                        ball_y_d = 12'(CENTRE_Y);
                        dir_x_d  = ~p1_score;
`ifdef BALL_SPEEDUP_EN
                        x_speed_d = 4'(X_SPEED);
                        hit_cnt_d = '0;
`endif
                    end else begin
                        dir_x_d = dir_x_eff;
`ifdef BALL_SPEEDUP_EN
                        if (paddle_hit) begin
                            hit_cnt_d = hit_cnt + 1'b1;
                            if (hit_cnt == 2'd3 && x_speed_q < 4'(X_SPEED_MAX))
                                x_speed_d = x_speed_q + 1'b1;
                        end
`endif
                        if (frame_tick) begin
                            ball_x_d = x_step_pos;
                            dir_x_d  = x_step_dir;
                            ball_y_d = y_step_pos;
                            dir_y_d  = y_step_dir;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            ball_x  <= 12'(CENTRE_X);
            ball_y  <= 12'(CENTRE_Y);
            dir_x   <= 1'b1;
            dir_y   <= 1'b0;
            speed_y <= 2'd1;
`ifdef BALL_SPEEDUP_EN
            x_speed_q <= 4'(X_SPEED);
            hit_cnt   <= '0;
`endif
        end else begin
            cnt     <= cnt_d;
            ball_x  <= ball_x_d;
            ball_y  <= ball_y_d;
            dir_x   <= dir_x_d;
            dir_y   <= dir_y_d;
            speed_y <= speed_y_d;
`ifdef BALL_SPEEDUP_EN
            x_speed_q <= x_speed_d;
            hit_cnt   <= hit_cnt_d;
`endif
        end
    end

    // rand_in is sampled during the single LAUNCH cycle, so the advance strobe is that cycle.
    assign rand_adv  = (state == LAUNCH) && game_en;
    assign ball_live = (state == LIVE);
    assign state_o   = state;

endmodule

// File: tb/tb_ball_serve_ctrl.sv
// Directed self-checking bench for ball_serve_ctrl: serve timing, launch mapping, walls,
// edges, scoring, paddle hits, game_en drop and asynchronous reset.
`timescale 1ns/1ps
module tb_ball_serve_ctrl;

    logic        clk = 1'b0;
    logic        rst, frame_tick, game_en, p1_score, p2_score, paddle_hit;
    logic [1:0]  rand_in;
    logic        rand_adv, dir_x, dir_y, ball_live;
    logic [11:0] ball_x, ball_y;
    logic [1:0]  speed_y, state_o;

    int total    = 0;
    int failures = 0;

    ball_serve_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_en(game_en),
        .p1_score(p1_score), .p2_score(p2_score), .paddle_hit(paddle_hit),
        .rand_in(rand_in), .rand_adv(rand_adv), .ball_x(ball_x), .ball_y(ball_y),
        .dir_x(dir_x), .dir_y(dir_y), .speed_y(speed_y), .ball_live(ball_live),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Each frame is a one-cycle tick followed by an idle cycle; returns at a negedge.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; frame_tick = 1'b0; game_en = 1'b0;
        p1_score = 1'b0; p2_score = 1'b0; paddle_hit = 1'b0; rand_in = 2'd0;
        #2 rst = 1'b1;
        #10;
        check("reset_state",   state_o,   0);
        check("reset_ball_x",  ball_x,    316);
        check("reset_ball_y",  ball_y,    236);
        check("reset_dir_x",   dir_x,     1);
        check("reset_dir_y",   dir_y,     0);
        check("reset_speed_y", speed_y,   1);
        check("reset_adv",     rand_adv,  0);
        check("reset_live",    ball_live, 0);
        @(negedge clk) rst = 1'b0;

        // First serve: 59 ticks stay in HOLD, the 60th launches.
        game_en = 1'b1;
        @(negedge clk);
        check("idle_to_hold", state_o, 1);
        frames(59);
        check("hold_after_59", state_o, 1);
        rand_in = 2'd2;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("launch_on_60", state_o, 2);
        check("adv_in_launch", rand_adv, 1);
        @(negedge clk);
        check("live_state", state_o, 3);
        check("adv_one_cycle", rand_adv, 0);
        check("launch2_speed", speed_y, 2);
        check("launch2_dir_y", dir_y, 0);
        check("ball_live", ball_live, 1);
        frames(1);
        check("first_move_x", ball_x, 318);
        check("first_move_y", ball_y, 234);

        // Paddle hit without a tick only reverses; then travel left to x=100.
        paddle_hit = 1'b1;
        @(negedge clk);
        paddle_hit = 1'b0;
        check("hit_dir_x", dir_x, 0);
        check("hit_no_move", ball_x, 318);
        frames(109);
        check("travel_x", ball_x, 100);
        check("travel_y", ball_y, 16);
        paddle_hit = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        paddle_hit = 1'b0; frame_tick = 1'b0;
        check("hit_tick_dir_x", dir_x, 1);
        check("hit_tick_x", ball_x, 102);
        check("hit_tick_y", ball_y, 14);

        // Simultaneous scores: p1 wins, serve toward player 1.
        p1_score = 1'b1; p2_score = 1'b1;
        @(negedge clk);
        p1_score = 1'b0; p2_score = 1'b0;
        check("both_score_state", state_o, 1);
        check("both_score_x", ball_x, 316);
        check("both_score_y", ball_y, 236);
        check("both_score_dir_x", dir_x, 0);
        frames(30);
        p2_score = 1'b1;
        @(negedge clk);
        p2_score = 1'b0;
        check("p2_hold_dir_x", dir_x, 1);
        check("p2_hold_state", state_o, 1);
        frames(59);
        check("restart_no_launch", state_o, 1);
        rand_in = 2'd0;
        frames(1);
        check("launch0_state", state_o, 3);
        check("launch0_speed", speed_y, 1);
        check("launch0_dir_y", dir_y, 0);

        // game_en drop in LIVE.
        frames(1);
        check("move_x_speed1", ball_x, 318);
        check("move_y_speed1", ball_y, 235);
        game_en = 1'b0;
        @(negedge clk);
        check("drop_state", state_o, 0);
        check("drop_x", ball_x, 316);
        check("drop_y", ball_y, 236);
        check("drop_live", ball_live, 0);

        // Serve with rand_in=3, then bottom wall, right edge and top wall.
        game_en = 1'b1;
        @(negedge clk);
        rand_in = 2'd3;
        frames(60);
        check("launch3_state", state_o, 3);
        check("launch3_speed", speed_y, 3);
        check("launch3_dir_y", dir_y, 1);
        frames(78);
        check("near_bottom_y", ball_y, 470);
        frames(1);
        check("bottom_clamp_y", ball_y, 472);
        check("bottom_dir_y", dir_y, 0);
        check("bottom_x", ball_x, 474);
        frames(157);
        check("up_y1", ball_y, 1);
        check("right_clamp_x", ball_x, 632);
        check("right_no_bounce", dir_x, 1);
        frames(1);
        check("top_clamp_y", ball_y, 0);
        check("top_dir_y", dir_y, 1);

        // Left edge: clamp at 0 with no bounce.
        paddle_hit = 1'b1;
        @(negedge clk);
        paddle_hit = 1'b0;
        frames(317);
        check("left_clamp_x", ball_x, 0);
        check("left_no_bounce", dir_x, 0);

        // Asynchronous reset mid-HOLD, observed before any clock edge.
        p1_score = 1'b1;
        @(negedge clk);
        p1_score = 1'b0;
        check("p1_live_state", state_o, 1);
        frames(5);
        rst = 1'b1;
        #1;
        check("async_rst_state", state_o, 0);
        check("async_rst_dir_x", dir_x, 1);
        check("async_rst_speed", speed_y, 1);
        check("async_rst_x", ball_x, 316);
        check("async_rst_y", ball_y, 236);
        @(negedge clk) rst = 1'b0;

`ifdef BALL_SPEEDUP_EN
        @(negedge clk);
        rand_in = 2'd1;
        frames(60);
        for (int i = 0; i < 4; i++) begin
            paddle_hit = 1'b1;
            @(negedge clk);
            paddle_hit = 1'b0;
            @(negedge clk);
        end
        frames(1);
        check("speedup_4th_hit", ball_x, 319);
        for (int i = 0; i < 16; i++) begin
            paddle_hit = 1'b1;
            @(negedge clk);
            paddle_hit = 1'b0;
            @(negedge clk);
        end
        frames(1);
        check("speedup_capped", ball_x, 325);
`endif

        $display("%0d/%0d checks passed", total - failures, total);
        $finish;
    end

endmodule
